// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: funct3 encodings,
// FSM state type and the default bus timeout.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load-data formatter: picks the addressed byte/halfword lane
// out of the bus word and sign- or zero-extends it to 32 bits.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] MemRdata,
  input  logic [1:0]  Addr,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData
);

  logic [31:0] shifted;

  // Move the addressed lane down to bit 0, then extend according to funct3.
  always_comb begin
    shifted  = MemRdata >> {Addr, 3'b000};
    ReadData = '0;
    case (Funct3)
      F3_B:    ReadData = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ReadData = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    ReadData = MemRdata;
      F3_BU:   ReadData = {24'b0, shifted[7:0]};
      F3_HU:   ReadData = {16'b0, shifted[15:0]};
      default: ReadData = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: turns a MEM-stage load/store into one request on a
// single-outstanding req/ack bus, stalls the pipeline until it completes, and
// reports misaligned, illegal or timed-out accesses through Err.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic        RespValid,
  output logic [31:0] ReadData,
  output logic        Err,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBe,
  output logic [31:0] MemWdata,
  input  logic        MemAck,
  input  logic [31:0] MemRdata
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [3:0]  be_reg, be_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [2:0]  f3_reg, f3_next;
  logic [1:0]  lane_reg, lane_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;

  logic        access;
  logic        illegal;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] fmt_data;

  assign access = Valid & (MemRead | MemWrite);

  // Decode conditions that must never reach the bus.
  assign illegal = (MemRead & MemWrite)
                 | (Funct3 == 3'b011)
                 | (Funct3[2:1] == 2'b11)
                 | (MemWrite & Funct3[2])
                 | ((Funct3[1:0] == 2'b01) & Addr[0])
                 | ((Funct3 == F3_W) & (Addr[1:0] != 2'b00));

  // Byte enables and lane-replicated store data for the incoming access.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = WriteData;
    case (Funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << Addr[1:0];
        wdata_calc = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_calc    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{WriteData[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = WriteData;
      end
    endcase
  end

  // Lane select/extension works on the size and offset captured at acceptance.
  load_formatter u_load_formatter (
    .MemRdata (MemRdata),
    .Addr     (lane_reg),
    .Funct3   (f3_reg),
    .ReadData (fmt_data)
  );

  // State and captured bus/response fields; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      be_reg    <= '0;
      wdata_reg <= '0;
      f3_reg    <= '0;
      lane_reg  <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      be_reg    <= be_next;
      wdata_reg <= wdata_next;
      f3_reg    <= f3_next;
      lane_reg  <= lane_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic: accept in IDLE, wait for ack or timeout, one response cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    be_next    = be_reg;
    wdata_next = wdata_reg;
    f3_next    = f3_reg;
    lane_next  = lane_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            state_next = RESP;
            err_next   = 1'b1;
            rdata_next = '0;
          end else begin
            state_next = WAIT;
            cnt_next   = '0;
            req_next   = 1'b1;
            we_next    = MemWrite;
            addr_next  = {Addr[31:2], 2'b00};
            be_next    = be_calc;
            wdata_next = wdata_calc;
            f3_next    = Funct3;
            lane_next  = Addr[1:0];
          end
        end
      end
      WAIT: begin
        // An ack in the final counted cycle still wins over the timeout.
        if (MemAck) begin
          state_next = RESP;
          req_next   = 1'b0;
          err_next   = 1'b0;
          rdata_next = we_reg ? 32'h0 : fmt_data;
        end else if (cnt_reg + 8'd1 == TIMEOUT_CNT) begin
          state_next = RESP;
          req_next   = 1'b0;
          err_next   = 1'b1;
          rdata_next = '0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RESP: begin
        // The finished instruction is still on the inputs; do not look at them.
        state_next = IDLE;
        cnt_next   = '0;
        err_next   = 1'b0;
        rdata_next = '0;
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  // Stall is gated by reset so every output is quiet while rst_n is low.
  assign Stall     = rst_n & ((state_reg == WAIT) | ((state_reg == IDLE) & access));
  assign RespValid = (state_reg == RESP);
  assign ReadData  = rdata_reg;
  assign Err       = err_reg;
  assign MemReq    = req_reg;
  assign MemWe     = we_reg;
  assign MemAddr   = addr_reg;
  assign MemBe     = be_reg;
  assign MemWdata  = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a spec-level access model.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Valid, MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WriteData;
  logic        Stall, RespValid, Err, MemReq, MemWe;
  logic [31:0] ReadData, MemAddr, MemWdata;
  logic [3:0]  MemBe;
  logic        MemAck;
  logic [31:0] MemRdata;

  int tests = 0;
  int fails = 0;

  logic        chk_en = 1'b0;
  logic [31:0] exp_rdata;
  logic        exp_err;

  int          last_k, last_req;
  logic [31:0] last_rdata, last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we, last_err;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .Valid(Valid), .MemRead(MemRead),
    .MemWrite(MemWrite), .Funct3(Funct3), .Addr(Addr), .WriteData(WriteData),
    .Stall(Stall), .RespValid(RespValid), .ReadData(ReadData), .Err(Err),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe),
    .MemWdata(MemWdata), .MemAck(MemAck), .MemRdata(MemRdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // ---- behavioural model ----
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_illegal(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (wr && f3 >= 4) return 1'b1;
    if ((int'(a[1:0]) % nbytes(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int off = int'(a[1:0]);
    int n = nbytes(f3);
    logic [3:0] be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n = nbytes(f3);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] word);
    logic [31:0] v = word >> (8 * int'(a[1:0]));
    int n = nbytes(f3);
    if (n == 1) begin
      v = {24'b0, v[7:0]};
      if (f3 < 4 && v[7]) v[31:8] = '1;
    end else if (n == 2) begin
      v = {16'b0, v[15:0]};
      if (f3 < 4 && v[15]) v[31:16] = '1;
    end
    return v;
  endfunction

  // ---- per-cycle comparison against the model ----
  task automatic cmp_cycle();
    check("stall", {31'b0, Stall}, {31'b0, Valid && (MemRead || MemWrite) && !RespValid});
    if (MemReq) begin
      check("bus_addr", MemAddr, {Addr[31:2], 2'b00});
      check("bus_be", {28'b0, MemBe}, {28'b0, m_be(Funct3, Addr)});
      check("bus_we", {31'b0, MemWe}, {31'b0, MemWrite});
      if (MemWrite) check("bus_wdata", MemWdata, m_wdata(Funct3, WriteData));
    end
    if (RespValid) begin
      check("resp_rdata", ReadData, exp_rdata);
      check("resp_err", {31'b0, Err}, {31'b0, exp_err});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (chk_en && rst_n) cmp_cycle();
  endtask

  // One access; delay = bus cycles before MemAck (0 = ack in first MemReq cycle), -1 = never.
  task automatic do_access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int delay,
                           input logic [31:0] word);
    bit ill = m_illegal(rd, wr, f3, a);
    bit acked = !ill && delay >= 0 && delay < TO;
    int exp_k, exp_req;
    Valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WriteData = wd;
    exp_err   = !acked;
    exp_rdata = (acked && !wr) ? m_load(f3, a, word) : 32'h0;
    chk_en = 1'b1;
    last_k = -1; last_req = 0;
    #1;
    cmp_cycle();
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (MemReq) begin
        last_req++;
        last_addr = MemAddr; last_be = MemBe; last_wdata = MemWdata; last_we = MemWe;
      end
      if (RespValid) begin
        last_k = k; last_rdata = ReadData; last_err = Err;
        MemAck = 1'b0; Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        break;
      end
      MemAck   = MemReq && delay >= 0 && (last_req - 1 == delay);
      MemRdata = MemAck ? word : 32'h0BAD_F00D;
    end
    exp_k   = ill ? 1 : (acked ? delay + 2 : TO + 1);
    exp_req = ill ? 0 : (acked ? delay + 1 : TO);
    check({name, "_resp_cycle"}, last_k, exp_k);
    check({name, "_req_cycles"}, last_req, exp_req);
    tick();
    check({name, "_idle_after"}, {30'b0, MemReq, RespValid}, 32'h0);
    $display("[TB] %s f3=%0d addr=0x%08h resp@%0d err=%0b rdata=0x%08h", name, f3, a,
             last_k, last_err, last_rdata);
  endtask

  initial begin
    rst_n = 1'b0; Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
    Addr = '0; WriteData = '0; MemAck = 1'b0; MemRdata = '0;
    #2;
    check("reset_ctrl", {Stall, RespValid, Err, MemReq, MemWe, MemBe}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_ctrl", {Stall, RespValid, Err, MemReq, MemWe, MemBe}, 32'h0);
    check("post_reset_addr", MemAddr, 32'h0);
    check("post_reset_rdata", ReadData, 32'h0);

    do_access("lw", 1, 0, F3_W, 32'h100, 0, 0, 32'hDEADBEEF);
    check("lw_addr_lit", last_addr, 32'h100);
    check("lw_be_lit", {28'b0, last_be}, 32'hF);
    check("lw_rdata_lit", last_rdata, 32'hDEADBEEF);
    check("lw_err_lit", {31'b0, last_err}, 32'h0);

    do_access("lb", 1, 0, F3_B, 32'h103, 0, 1, 32'h80FF_0000);
    check("lb_be_lit", {28'b0, last_be}, 32'h8);
    check("lb_rdata_lit", last_rdata, 32'hFFFFFF80);
    do_access("lbu", 1, 0, F3_BU, 32'h103, 0, 2, 32'h80FF_0000);
    check("lbu_rdata_lit", last_rdata, 32'h00000080);

    do_access("sh", 0, 1, F3_H, 32'h202, 32'h1234ABCD, 0, 32'h0);
    check("sh_we_lit", {31'b0, last_we}, 32'h1);
    check("sh_addr_lit", last_addr, 32'h200);
    check("sh_be_lit", {28'b0, last_be}, 32'hC);
    check("sh_wdata_lit", last_wdata, 32'hABCDABCD);
    check("sh_rdata_lit", last_rdata, 32'h0);

    do_access("sb", 0, 1, F3_B, 32'h001, 32'h0000005A, 1, 32'h0);
    check("sb_be_lit", {28'b0, last_be}, 32'h2);
    check("sb_wdata_lit", last_wdata, 32'h5A5A5A5A);
    do_access("lh", 1, 0, F3_H, 32'h102, 0, 0, 32'h8001_1234);
    check("lh_rdata_lit", last_rdata, 32'hFFFF8001);
    do_access("lhu", 1, 0, F3_HU, 32'h100, 0, 0, 32'h8001_F234);
    check("lhu_rdata_lit", last_rdata, 32'h0000F234);

    do_access("lw_mis", 1, 0, F3_W, 32'h101, 0, 0, 32'h0);
    check("lw_mis_err_lit", {31'b0, last_err}, 32'h1);
    do_access("rdwr", 1, 1, F3_W, 32'h100, 0, 0, 32'h0);
    check("rdwr_err_lit", {31'b0, last_err}, 32'h1);
    do_access("lh_odd", 1, 0, F3_H, 32'h103, 0, 0, 32'h0);
    do_access("f3_011", 1, 0, 3'b011, 32'h100, 0, 0, 32'h0);
    do_access("sbu", 0, 1, F3_BU, 32'h100, 0, 0, 32'h0);

    do_access("timeout", 1, 0, F3_W, 32'h300, 0, -1, 32'h0);
    check("timeout_req_lit", last_req, 32'd4);
    check("timeout_err_lit", {31'b0, last_err}, 32'h1);
    check("timeout_rdata_lit", last_rdata, 32'h0);
    do_access("ack_last", 1, 0, F3_W, 32'h304, 0, TO - 1, 32'h13579BDF);
    check("ack_last_err_lit", {31'b0, last_err}, 32'h0);

    // Stray ack while idle must not produce a response.
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    tick();
    check("stray_ack", {30'b0, RespValid, MemReq}, 32'h0);

    // Reset in the middle of a bus wait.
    Valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = F3_W; Addr = 32'h400;
    exp_err = 1'b1; exp_rdata = 32'h0;
    tick(); tick();
    check("pre_reset_req", {31'b0, MemReq}, 32'h1);
    rst_n = 1'b0;
    chk_en = 1'b0;
    #1;
    check("rst_ctrl", {Stall, RespValid, Err, MemReq, MemWe, MemBe}, 32'h0);
    check("rst_addr", MemAddr, 32'h0);
    check("rst_wdata", MemWdata, 32'h0);
    check("rst_rdata", ReadData, 32'h0);
    Valid = 1'b0; MemRead = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_access("sw", 0, 1, F3_W, 32'h500, 32'hCAFEF00D, 1, 32'h0);
    check("sw_wdata_lit", last_wdata, 32'hCAFEF00D);
    check("sw_err_lit", {31'b0, last_err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
